// File: rtl/service_protocol_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : service_protocol_packer_if
// Description : Control, data-push and transmit-push bus of the service
//               protocol packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface service_protocol_packer_if #(
  parameter int WORD_W = 16
);
  // packet control
  logic              enable;
  logic              pkt_start;
  logic [WORD_W-1:0] pkt_addr;
  logic [7:0]        pkt_size;
  logic [7:0]        pkt_cmd;
  logic              busy;
  logic              pkt_done;
  logic [WORD_W-1:0] pkt_num;
  // data push from the packet source
  logic [WORD_W-1:0] in_data;
  logic              in_request;
  logic              in_done;
  // word push towards the SPI transmitter
  logic [WORD_W-1:0] out_data;
  logic              out_request;
  logic              out_done;

  // packet source / transmitter side
  modport master (
    output enable, pkt_start, pkt_addr, pkt_size, pkt_cmd,
    output in_data, in_request, out_done,
    input  busy, pkt_done, pkt_num, in_done, out_data, out_request
  );

  // packer side
  modport slave (
    input  enable, pkt_start, pkt_addr, pkt_size, pkt_cmd,
    input  in_data, in_request, out_done,
    output busy, pkt_done, pkt_num, in_done, out_data, out_request
  );
endinterface
`default_nettype wire

// File: rtl/service_protocol_packer.sv
`default_nettype none
// ============================================================================
// Module      : service_protocol_packer
// Description : Transmit-side framer. Emits HEAD1=addr, HEAD2={size,cmd},
//               size data words, CRC (16-bit sum) and the packet number.
// Revision    : 1.0 - initial release
// ============================================================================
module service_protocol_packer #(
  parameter int                 WORD_W   = 16,
  parameter logic [WORD_W-1:0]  NUM_INIT = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  service_protocol_packer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD1 = 3'd1,
    S_HEAD2 = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_NUM   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_req_q, out_req_d;
  logic              pend_q, pend_d;        // a word has been requested and not yet acked
  logic [WORD_W-1:0] crc_q, crc_d;
  logic [7:0]        cntr_q, cntr_d;
  logic [7:0]        size_q, size_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [WORD_W-1:0] num_q, num_d;
  logic              pkt_done_q, pkt_done_d;
  logic              in_done_q, in_done_d;

  logic              w_ack;
  logic [WORD_W-1:0] w_head2;

  // An ack only counts for an outstanding word, and never in the request cycle itself
  assign w_ack   = pend_q & ~out_req_q & bus.out_done;
  assign w_head2 = WORD_W'({size_q, cmd_q});

  // Next-state and next-output computation for the framing sequence
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_req_d  = 1'b0;
    pend_d     = pend_q;
    crc_d      = crc_q;
    cntr_d     = cntr_q;
    size_d     = size_q;
    cmd_d      = cmd_q;
    num_d      = num_q;
    pkt_done_d = 1'b0;
    in_done_d  = 1'b0;

    if (!bus.enable && state_q != S_IDLE) begin
      // session dropped: abandon the packet and any word in flight
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.enable && bus.pkt_start) begin
            size_d     = bus.pkt_size;
            cmd_d      = bus.pkt_cmd;
            out_data_d = bus.pkt_addr;
            crc_d      = bus.pkt_addr;
            out_req_d  = 1'b1;
            pend_d     = 1'b1;
            state_d    = S_HEAD1;
          end
        end
        S_HEAD1: begin
          if (w_ack) begin
            out_data_d = w_head2;
            crc_d      = crc_q + w_head2;
            out_req_d  = 1'b1;
            pend_d     = 1'b1;
            state_d    = S_HEAD2;
          end
        end
        S_HEAD2: begin
          if (w_ack) begin
            cntr_d = '0;
            if (size_q == 8'd0) begin
              out_data_d = crc_q;
              out_req_d  = 1'b1;
              pend_d     = 1'b1;
              state_d    = S_CRC;
            end else begin
              pend_d  = 1'b0;
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          // an ack wins over a simultaneous push; the push is dropped
          if (w_ack) begin
            in_done_d = 1'b1;
            pend_d    = 1'b0;
            cntr_d    = cntr_q + 8'd1;
            if ((cntr_q + 8'd1) == size_q) begin
              out_data_d = crc_q;
              out_req_d  = 1'b1;
              pend_d     = 1'b1;
              state_d    = S_CRC;
            end
          end else if (!pend_q && bus.in_request) begin
            out_data_d = bus.in_data;
            crc_d      = crc_q + bus.in_data;
            out_req_d  = 1'b1;
            pend_d     = 1'b1;
          end
        end
        S_CRC: begin
          if (w_ack) begin
            out_data_d = num_q;
            out_req_d  = 1'b1;
            pend_d     = 1'b1;
            state_d    = S_NUM;
          end
        end
        S_NUM: begin
          if (w_ack) begin
            pkt_done_d = 1'b1;
            num_d      = num_q + 1'b1;
            pend_d     = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      out_data_q <= '0;
      out_req_q  <= 1'b0;
      pend_q     <= 1'b0;
      crc_q      <= '0;
      cntr_q     <= '0;
      size_q     <= '0;
      cmd_q      <= '0;
      num_q      <= NUM_INIT;
      pkt_done_q <= 1'b0;
      in_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_req_q  <= out_req_d;
      pend_q     <= pend_d;
      crc_q      <= crc_d;
      cntr_q     <= cntr_d;
      size_q     <= size_d;
      cmd_q      <= cmd_d;
      num_q      <= num_d;
      pkt_done_q <= pkt_done_d;
      in_done_q  <= in_done_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.pkt_done    = pkt_done_q;
  assign bus.pkt_num     = num_q;
  assign bus.in_done     = in_done_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_request = out_req_q;

endmodule
`default_nettype wire
